// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp, approach, fault and state constants for the lamp monitor
package traffic_pkg;

  // Lamp codes on the bus, one-hot per approach
  localparam logic [2:0] LAMP_GREEN = 3'b001;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_RED   = 3'b100;

  // Approach indices, also the phase encoding
  localparam logic [1:0] APP_N = 2'd0;
  localparam logic [1:0] APP_S = 2'd1;
  localparam logic [1:0] APP_E = 2'd2;
  localparam logic [1:0] APP_W = 2'd3;

  // Fault codes; a lower value wins when several fire together
  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_ILLEGAL  = 3'd1;
  localparam logic [2:0] FLT_CONFLICT = 3'd2;
  localparam logic [2:0] FLT_SHORT    = 3'd3;
  localparam logic [2:0] FLT_LONG     = 3'd4;
  localparam logic [2:0] FLT_GAP_LONG = 3'd5;
  localparam logic [2:0] FLT_SEQ      = 3'd6;

  // Tracker state
  typedef logic [1:0] mon_state_t;
  localparam mon_state_t ST_IDLE  = 2'd0;
  localparam mon_state_t ST_GREEN = 2'd1;
  localparam mon_state_t ST_GAP   = 2'd2;

  // A lamp code is legal only when exactly one of green/amber/red is lit
  function automatic logic lamp_code_legal(input logic [2:0] code);
    return (code == LAMP_GREEN) || (code == LAMP_AMBER) || (code == LAMP_RED);
  endfunction

endpackage

// File: rtl/traffic_lamp_monitor_lamp_decode.sv
// rtl/traffic_lamp_monitor_lamp_decode.sv - combinational decode of the four sampled lamp codes
module lamp_decode
  import traffic_pkg::*;
(
  input  logic [2:0] i_lamp_n,
  input  logic [2:0] i_lamp_s,
  input  logic [2:0] i_lamp_e,
  input  logic [2:0] i_lamp_w,
  output logic [3:0] o_illegal,
  output logic [2:0] o_green_cnt,
  output logic [1:0] o_green_idx
);

  logic [11:0] w_bus;

  // Index 0 is N so the loop index equals the approach/phase encoding
  assign w_bus = {i_lamp_w, i_lamp_e, i_lamp_s, i_lamp_n};

  // Flag non-one-hot codes, count greens and remember which approach is green
  always_comb begin
    o_illegal   = '0;
    o_green_cnt = '0;
    o_green_idx = '0;
    for (int i = 0; i < 4; i++) begin
      o_illegal[i] = !lamp_code_legal(w_bus[3*i +: 3]);
      if (w_bus[3*i +: 3] == LAMP_GREEN) begin
        o_green_cnt = o_green_cnt + 3'd1;
        o_green_idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// rtl/traffic_lamp_monitor.sv - passive lamp-bus checker; TLM_SEQ_CHECK_EN enables the phase order check
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 16,
  parameter int GAP_MAX   = 4
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_lamp_n,
  input  logic [2:0] i_lamp_s,
  input  logic [2:0] i_lamp_e,
  input  logic [2:0] i_lamp_w,
  output logic [1:0] o_phase,
  output logic       o_phase_valid,
  output logic       o_phase_done,
  output logic [4:0] o_dwell,
  output logic [2:0] o_fault_code,
  output logic       o_fault_pulse,
  output logic       o_fault
);

  localparam logic [4:0] L_GREEN_MIN = 5'(GREEN_MIN);
  localparam logic [4:0] L_GREEN_MAX = 5'(GREEN_MAX);
  localparam logic [4:0] L_GAP_MAX   = 5'(GAP_MAX);
  localparam logic [4:0] L_CNT_SAT   = 5'd31;

  logic [2:0] r_lamp_n, r_lamp_s, r_lamp_e, r_lamp_w;
  mon_state_t r_state;
  logic [1:0] r_phase;
  logic [4:0] r_dwell_cnt;
  logic [4:0] r_gap_cnt;
  logic       r_phase_done;
  logic [4:0] r_dwell;
  logic [2:0] r_fault_code;
  logic       r_fault_pulse;
  logic       r_fault;

  logic [3:0] w_illegal;
  logic [2:0] w_green_cnt;
  logic [1:0] w_green_idx;
  logic       w_single;
  mon_state_t w_state_nxt;
  logic [1:0] w_phase_nxt;
  logic [4:0] w_dwell_cnt_nxt;
  logic [4:0] w_gap_cnt_nxt;
  logic       w_done_nxt;
  logic [4:0] w_dwell_nxt;
  logic [6:1] w_flags;
  logic [2:0] w_code_nxt;

  lamp_decode u_decode (
    .i_lamp_n    (r_lamp_n),
    .i_lamp_s    (r_lamp_s),
    .i_lamp_e    (r_lamp_e),
    .i_lamp_w    (r_lamp_w),
    .o_illegal   (w_illegal),
    .o_green_cnt (w_green_cnt),
    .o_green_idx (w_green_idx)
  );

  assign w_single = (w_green_cnt == 3'd1);

  // Register the bus; reset to all-red so the first post-reset sample is benign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lamp_n <= LAMP_RED;
      r_lamp_s <= LAMP_RED;
      r_lamp_e <= LAMP_RED;
      r_lamp_w <= LAMP_RED;
    end else begin
      r_lamp_n <= i_lamp_n;
      r_lamp_s <= i_lamp_s;
      r_lamp_e <= i_lamp_e;
      r_lamp_w <= i_lamp_w;
    end
  end

  // Tracker next state, phase end detection and per-cycle fault flags
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_dwell_cnt_nxt = r_dwell_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_done_nxt      = 1'b0;
    w_dwell_nxt     = r_dwell;
    w_flags         = '0;
    w_code_nxt      = FLT_NONE;

    w_flags[FLT_ILLEGAL]  = |w_illegal;
    w_flags[FLT_CONFLICT] = (w_green_cnt >= 3'd2);

    case (r_state)
      ST_IDLE: begin
        if (w_single) begin
          w_state_nxt     = ST_GREEN;
          w_phase_nxt     = w_green_idx;
          w_dwell_cnt_nxt = 5'd1;
        end
      end
      ST_GREEN: begin
        if (w_single && (w_green_idx == r_phase)) begin
          if (r_dwell_cnt != L_CNT_SAT) w_dwell_cnt_nxt = r_dwell_cnt + 5'd1;
          // Equality before the increment fires exactly once per phase
          if (r_dwell_cnt == L_GREEN_MAX) w_flags[FLT_LONG] = 1'b1;
        end else begin
          w_done_nxt  = 1'b1;
          w_dwell_nxt = r_dwell_cnt;
          if (r_dwell_cnt < L_GREEN_MIN) w_flags[FLT_SHORT] = 1'b1;
          if (w_single) begin
            w_phase_nxt     = w_green_idx;
            w_dwell_cnt_nxt = 5'd1;
          end else begin
            w_state_nxt     = ST_GAP;
            w_gap_cnt_nxt   = 5'd1;
            w_dwell_cnt_nxt = 5'd0;
          end
        end
      end
      ST_GAP: begin
        if (w_single) begin
          w_state_nxt     = ST_GREEN;
          w_phase_nxt     = w_green_idx;
          w_dwell_cnt_nxt = 5'd1;
          w_gap_cnt_nxt   = 5'd0;
        end else if (w_green_cnt == 3'd0) begin
          if (r_gap_cnt != L_CNT_SAT) w_gap_cnt_nxt = r_gap_cnt + 5'd1;
          if (r_gap_cnt == L_GAP_MAX) w_flags[FLT_GAP_LONG] = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

`ifdef TLM_SEQ_CHECK_EN
    // A new phase must be the successor of the last one; it is adopted regardless
    w_flags[FLT_SEQ] = w_single &&
                       ((r_state == ST_GAP) || ((r_state == ST_GREEN) && (w_green_idx != r_phase))) &&
                       (w_green_idx != (r_phase + 2'd1));
`endif

    for (int i = 6; i >= 1; i--) begin
      if (w_flags[i]) w_code_nxt = 3'(i);
    end
  end

  // Tracker and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= APP_N;
      r_dwell_cnt   <= '0;
      r_gap_cnt     <= '0;
      r_phase_done  <= 1'b0;
      r_dwell       <= '0;
      r_fault_code  <= FLT_NONE;
      r_fault_pulse <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_dwell_cnt   <= w_dwell_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_phase_done  <= w_done_nxt;
      r_dwell       <= w_dwell_nxt;
      r_fault_code  <= w_code_nxt;
      r_fault_pulse <= |w_flags;
      r_fault       <= r_fault | (|w_flags);
    end
  end

  assign o_phase       = r_phase;
  assign o_phase_valid = (r_state == ST_GREEN);
  assign o_phase_done  = r_phase_done;
  assign o_dwell       = r_dwell;
  assign o_fault_code  = r_fault_code;
  assign o_fault_pulse = r_fault_pulse;
  assign o_fault       = r_fault;

endmodule

// File: doc/traffic_lamp_monitor.md
# traffic_lamp_monitor

Passive checker on the far side of the intersection lamp bus. It samples the four per-approach 3-bit lamp codes driven by the traffic controller and decodes the active green phase. It measures each green's dwell and flags illegal codes, conflicting greens, bad dwell, sequence errors and over-long clearance gaps. It sits beside the controller outputs, feeding the fault/diagnostic path; it never drives lamps.

## Interface
- GREEN_MIN, 8: minimum legal green dwell, in cycles.
- GREEN_MAX, 16: maximum legal green dwell, in cycles; must be ≤ 30.
- GAP_MAX, 4: maximum consecutive no-green cycles between phases.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- lamp_n, lamp_s, lamp_e, lamp_w  in  3 each  lamp code per approach: 3'b001 green, 3'b010 amber, 3'b100 red.
- phase  out  2  current green approach: 0 N, 1 S, 2 E, 3 W.
- phase_valid  out  1  a single legal green is currently decoded.
- phase_done  out  1  one-cycle pulse when a green phase ends.
- dwell  out  5  length of the last completed green, saturating at 31.
- fault_code  out  3  code of the highest-priority fault detected this cycle; 0 when none.
- fault_pulse  out  1  one-cycle pulse with any new fault.
- fault  out  1  sticky OR of all faults; cleared only by rst.

## Operation
- Input stage: all 12 lamp bits are registered every clk. All checks act on the registered copy, called the sample.
- Per approach, the code must be one-hot. Any other value (including 000) is ILLEGAL (fault_code 1). An illegal approach never counts as green.
- green_cnt is the number of approaches in the sample with code 001.
  - green_cnt ≥ 2 is CONFLICT (code 2).
- Tracker FSM:
  - IDLE (after reset):
    - green_cnt == 1 → GREEN. Latch phase, dwell counter = 1, no sequence check.
  - GREEN:
    - Same approach still the only green: increment the dwell counter, saturating at 31.
    - Dwell counter reaches GREEN_MAX+1: LONG (code 4), reported once per phase.
    - The sampled green disappears, or a different single approach becomes green: the phase ends. Assert phase_done, load dwell with the counter, and flag SHORT (code 3) if the counter < GREEN_MIN.
      - Direct handover to a new single green: start a new phase immediately with counter = 1 and run the sequence check.
      - Otherwise → GAP with gap counter = 1.
    - CONFLICT: ends the phase the same way (phase_done, dwell, SHORT check), then → GAP.
  - GAP:
    - green_cnt == 0: increment the gap counter. It exceeding GAP_MAX gives GAP_LONG (code 5), reported once per gap.
    - green_cnt == 1 → GREEN, with the sequence check.
- Sequence check: the expected next phase is (last phase + 1) mod 4, wrapping W→N. A mismatch is SEQ (code 6). The new phase is still adopted.
- phase_valid = 1 only in GREEN. phase holds its last value when not valid.
- Simultaneous faults:
  - fault_code shows the lowest nonzero code.
  - fault_pulse and fault assert for any of them.

## Timing
- Reset values: phase 0, phase_valid 0, phase_done 0, dwell 0, fault_code 0, fault_pulse 0, fault 0; FSM in IDLE; all counters 0.
- Latency: a lamp change at the bus before edge k is sampled at edge k. All outputs reflect it after edge k+1, a 2-cycle latency.
- phase_done, fault_pulse and fault_code are single-cycle registered outputs.
- Asserting rst mid-phase immediately clears all state. No phase_done is emitted for the aborted phase.
- The block has no backpressure; it evaluates every cycle.

## Configuration
- TLM_SEQ_CHECK_EN defined: the SEQ check runs, and code 6 is reachable.
- TLM_SEQ_CHECK_EN undefined:
  - No expected-phase register and no SEQ check; any approach order is legal.
  - All other checks are unchanged.

## Structure
- Shared package traffic_pkg holds:
  - lamp code constants LAMP_GREEN, LAMP_AMBER, LAMP_RED;
  - approach constants N/S/E/W as 2-bit values;
  - fault code constants FLT_NONE through FLT_SEQ;
  - the monitor state typedef (IDLE, GREEN, GAP).
- One sub-module, lamp_decode, is natural. It is combinational over the four samples and produces per-approach illegal flags, green_cnt, and the index of the single green.
- Counters and the FSM live in the top module.

## Test plan
- Four lamp patterns, each held 8 cycles, cycling N→S→E→W→N with direct handover (GREEN_MIN 8) → phase_done every 8 cycles, dwell 8, fault stays 0.
- N green held for 5 cycles, then S green → phase_done, dwell 5, fault_code 3, fault 1 and held until rst.
- N and E both 001 for one cycle → fault_code 2, and the FSM enters GAP.
- lamp_s = 3'b011 → fault_code 1. With a simultaneous second green, fault_code still shows 1.
- N green, then E green:
  - with TLM_SEQ_CHECK_EN → fault_code 6, phase = 2;
  - without it → no fault.
- All red for 6 cycles after a green (GAP_MAX 4) → exactly one fault_code 5 pulse. Asserting rst mid-green clears phase_valid, dwell and fault in the same cycle.
